ikeyrev256: RTL
===============

// Module: ikeyrev256
// PURPOSE
//   Reverse-order AES-256 round-key generator for the decryption path.
//   Loaded once with the final expansion block {RK13, RK14}, it walks the key schedule backwards.
//   It emits RK14, RK13, ..., RK0, one key per accepted handshake, for the inverse-cipher datapath.
//   Only one SubWord per step, so the expanded schedule is never stored.
// PARAMETERS
//   (none)  -  fixed to AES-256: Nk=8, Nr=14, 15 round keys
// PORTS
//   clk       in   1    system clock
//   reset     in   1    asynchronous, active-high reset
//   start     in   1    load lastKeys and begin a new reverse walk
//   lastKeys  in   256  {RK13,RK14} = words w[52..59]; w[52] in [255:224]
//   rkReady   in   1    consumer accepts roundKey this cycle
//   rkValid   out  1    roundKey/rkIndex valid
//   roundKey  out  128  current round key, first word in [127:96]
//   rkIndex   out  4    round number of roundKey (14..0)
//   rkLast    out  1    high with RK0 (rkIndex==0 while rkValid)
//   busy      out  1    FSM in RUN
//   done      out  1    one-cycle pulse after RK0 is accepted
// BEHAVIOUR
//   Regs: state{IDLE,RUN}, block[255:0] = {RK(r-1),RK(r)}, idx[3:0] = r, rcon[7:0], done.
//   Reset (async): state=IDLE, block=0, idx=0, rcon=8'h40, done=0.
//     All outputs 0 while in reset.
//   Outputs (combinational from regs):
//     rkValid = busy = (state==RUN); roundKey = RUN ? block[127:0] : 0;
//     rkIndex = RUN ? idx : 0; rkLast = rkValid & (idx==0).
//   start (any state, highest priority): next edge state=RUN, block=lastKeys, idx=14, rcon=8'h40.
//     An in-flight handshake in the same cycle is discarded; no done.
//   Latency: start sampled at edge N -> rkValid=1 with RK14 after edge N.
//   Fire = rkValid & rkReady & !start. No fire -> all regs hold (outputs stable under backpressure).
//   Step datapath, block words b0..b7 = w[4r-4..4r+3], b0 = block[255:224]:
//     g = r even ? SubWord(RotWord(b3)) ^ {rcon,24'h0} : SubWord(b3)
//     RotWord(x) = {x[23:0],x[31:24]}; SubWord = 4 forward S-boxes.
//     n0 = b4^g, n1 = b5^b4, n2 = b6^b5, n3 = b7^b6; newRK = {n0,n1,n2,n3} = RK(r-2).
//   On fire:
//     idx>=2 : block <= {newRK, block[255:128]}, idx <= idx-1.
//       If idx even, rcon <= rcon>>1 (0x40..0x01; no GF reduction needed).
//     idx==1 : block <= {128'h0, block[255:128]}, idx <= 0; no SubWord result used.
//     idx==0 : state <= IDLE, done <= 1 for exactly one cycle; block/idx hold.
//   done cleared every cycle it is not set; start during the done cycle is legal.
//   rkReady ignored in IDLE. lastKeys sampled only on start.
//   Back-to-back fires: one key per cycle; full walk = 15 accepted cycles.
//   Reset asserted mid-walk: immediate return to IDLE, no done, no partial output.
// TESTING
//   1 Reset: assert reset mid-cycle -> rkValid/busy/done/roundKey/rkIndex = 0 immediately.
//     Hold until start.
//   2 FIPS-197 C.3 key 000102..1f; lastKeys from the software expansion; rkReady=1.
//     -> roundKey = 24fc79ccbf0979e9371ac23c6d68de36, rkIndex=14, one cycle after start.
//     -> rkIndex 14..0 on consecutive cycles, each key matches the model.
//     -> RK1 = 101112131415161718191a1b1c1d1e1f.
//     -> RK0 = 000102030405060708090a0b0c0d0e0f with rkLast=1; done=1 next cycle only.
//   3 Random rkReady backpressure (~50%) on key 2: roundKey/rkIndex constant while stalled.
//     Accepted sequence identical to test 2; rcon stepping not disturbed.
//   4 FIPS-197 A.3 key 603deb10..0914dff4: start again at rkIndex=7.
//     -> next cycle rkIndex=14 with the new key's RK14; no done from the aborted walk.
//   5 start in the same cycle as the RK0 handshake -> restart wins, no done.
//     RK14 presented next cycle.
//   6 Idle checks: rkReady toggling in IDLE -> no state change.
//     Two walks back-to-back via start in the done cycle -> both sequences correct.

Source files
------------

// File: rtl/ikeyrev256_if.sv
// Purpose: handshake bundle between the reverse AES-256 key walker and its consumer.
// Latency: n/a (wires only).
// Backpressure: rkReady from the consumer stalls the walker; roundKey/rkIndex hold while stalled.
interface ikeyrev256_if;
    logic         start;
    logic [255:0] lastKeys;
    logic         rkReady;
    logic         rkValid;
    logic [127:0] roundKey;
    logic [3:0]   rkIndex;
    logic         rkLast;
    logic         busy;
    logic         done;

    // Consumer / controller side.
    modport master (
        output start, lastKeys, rkReady,
        input  rkValid, roundKey, rkIndex, rkLast, busy, done
    );

    // Key walker side.
    modport slave (
        input  start, lastKeys, rkReady,
        output rkValid, roundKey, rkIndex, rkLast, busy, done
    );
endinterface

// File: rtl/ikeyrev256.sv
// Purpose: walks the AES-256 key schedule backwards from {RK13,RK14}, emitting RK14..RK0.
// Latency: RK14 valid the cycle after start is sampled; one key per accepted handshake after that.
// Backpressure: without rkReady all state holds, so roundKey/rkIndex stay stable until accepted.
module ikeyrev256 (
    input  logic       clk,
    input  logic       reset,
    ikeyrev256_if.slave kif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [255:0]  block;     // {RK(r-1), RK(r)}
    logic [3:0]    idx;       // r
    logic [7:0]    rcon;
    logic          done_q;
    logic          fire;
    logic [31:0]   b3, b4, b5, b6, b7;
    logic [31:0]   sub_in;
    logic [31:0]   g;
    logic [127:0]  new_rk;

    // start pre-empts any handshake presented in the same cycle.
    assign fire = (state == RUN) && kif.rkReady && !kif.start;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: start always (re)enters RUN; accepting RK0 ends the walk.
    always_comb begin
        state_nxt = state;
        if (kif.start)                  state_nxt = RUN;
        else if (fire && idx == 4'd0)   state_nxt = IDLE;
    end

    // Outputs decode straight from the registers, so they are zero during reset.
    always_comb begin
        kif.rkValid  = (state == RUN);
        kif.busy     = (state == RUN);
        kif.roundKey = (state == RUN) ? block[127:0] : 128'h0;
        kif.rkIndex  = (state == RUN) ? idx : 4'd0;
        kif.rkLast   = (state == RUN) && (idx == 4'd0);
        kif.done     = done_q;
    end

    // Inverse expansion step: recover w[4r-8..4r-5] from w[4r-1..4r+3].
    always_comb begin
        b3     = block[159:128];
        b4     = block[127:96];
        b5     = block[95:64];
        b6     = block[63:32];
        b7     = block[31:0];
        sub_in = idx[0] ? b3 : {b3[23:0], b3[31:24]};
        g      = sub_word(sub_in) ^ (idx[0] ? 32'h0 : {rcon, 24'h0});
        new_rk = {b4 ^ g, b5 ^ b4, b6 ^ b5, b7 ^ b6};
    end

    // Schedule registers: load on start, shift one round key per accepted handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block  <= 256'h0;
            idx    <= 4'd0;
            rcon   <= 8'h40;
            done_q <= 1'b0;
        end else begin
            done_q <= fire && (idx == 4'd0);
            if (kif.start) begin
                block <= kif.lastKeys;
                idx   <= 4'd14;
                rcon  <= 8'h40;
            end else if (fire) begin
                if (idx >= 4'd2) begin
                    block <= {new_rk, block[255:128]};
                    idx   <= idx - 4'd1;
                    // Rcon only advances on even rounds; 0x40 down to 0x01 never needs reduction.
                    if (!idx[0]) rcon <= rcon >> 1;
                end else if (idx == 4'd1) begin
                    // RK0 is already held in the upper half; nothing left to derive.
                    block <= {128'h0, block[255:128]};
                    idx   <= 4'd0;
                end
            end
        end
    end

endmodule
